// File: rtl/spi_main_param_pkg.sv
// Shared state encoding, SPI mode constants and width helper for the
// parametrised SPI master.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_HOLD
    } spi_state_e;

    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    // Bits needed to index n items, never less than one.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_main_param_if.sv
// Host handshake plus SPI pins of one master; master modport faces the
// controller, slave modport faces host logic and the attached slaves.
interface spi_main_param_if import spi_pkg::*; #(
    parameter int MAX_BITS = 258,
    parameter int NUM_CS   = 2,
    parameter int LEN_W    = width_of(MAX_BITS + 1),
    parameter int CS_W     = width_of(NUM_CS)
);
    logic                start;
    logic [LEN_W-1:0]    len;
    logic [CS_W-1:0]     cs_sel;
    logic [0:MAX_BITS-1] tx;
    logic [0:MAX_BITS-1] rx;
    logic                busy;
    logic                done;
    logic                err;
    logic                sclk;
    logic                mosi;
    logic                miso;
    logic [NUM_CS-1:0]   cs_n;

    modport master (
        input  start, len, cs_sel, tx, miso,
        output rx, busy, done, err, sclk, mosi, cs_n
    );

    modport slave (
        output start, len, cs_sel, tx, miso,
        input  rx, busy, done, err, sclk, mosi, cs_n
    );
endinterface

// File: rtl/spi_main_param_sclk_gen.sv
// Half-period counter: strobes on the last clk of each SCLK half period,
// held cleared whenever the master is not in SETUP/SHIFT.
module spi_sclk_gen import spi_pkg::*; #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic phase_hi,
    output logic rise_stb,
    output logic fall_stb
);
    localparam int               DIV_W    = width_of(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt_q;
    logic             last;

    assign last     = run && (cnt_q == DIV_LAST);
    assign rise_stb = last && !phase_hi;
    assign fall_stb = last && phase_hi;

    always_ff @(posedge clk) begin
        if (rst || !run || last) cnt_q <= '0;
        else                     cnt_q <= cnt_q + DIV_W'(1);
    end
endmodule

// File: rtl/spi_main_param.sv
// Full-duplex SPI mode-0 master with runtime frame length, NUM_CS selects
// and a busy/done/err handshake; rx is published only on the done cycle.
module spi_main_param import spi_pkg::*; #(
    parameter int MAX_BITS = 258,
    parameter int CLK_DIV  = 2,
    parameter int NUM_CS   = 2
) (
    input  logic             clk,
    input  logic             rst,
    spi_main_param_if.master bus
);
    localparam int               LEN_W    = width_of(MAX_BITS + 1);
    localparam int               CS_W     = width_of(NUM_CS);
    localparam int               IDX_W    = width_of(MAX_BITS);
    localparam int               DIV_W    = width_of(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    spi_state_e          state_q, state_d;
    logic [LEN_W-1:0]    len_q, bit_cnt_q;
    logic [CS_W-1:0]     cs_q;
    logic [0:MAX_BITS-1] tx_sr, rx_sr, rx_q;
    logic [DIV_W-1:0]    hold_cnt_q;
    logic [IDX_W-1:0]    wr_idx;
    logic                done_q, err_q;
    logic                len_ok, cs_ok, req_ok, accept, hold_end, shifting;
    logic                rise_stb, fall_stb, capture_stb, launch_stb;

    // With a power-of-two NUM_CS every cs_sel encoding is a real slave.
    if (NUM_CS == (1 << CS_W)) begin : g_cs_full
        assign cs_ok = 1'b1;
    end else begin : g_cs_part
        assign cs_ok = bus.cs_sel < CS_W'(NUM_CS);
    end

    assign len_ok   = (bus.len != '0) && (bus.len <= LEN_W'(MAX_BITS));
    assign req_ok   = len_ok && cs_ok;
    assign accept   = (state_q == ST_IDLE) && bus.start && req_ok;
    assign hold_end = (state_q == ST_HOLD) && (hold_cnt_q == DIV_LAST);
    assign shifting = (state_q == ST_SETUP) || (state_q == ST_SHIFT_LO) ||
                      (state_q == ST_SHIFT_HI);
    assign wr_idx   = bit_cnt_q[IDX_W-1:0];

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk      (clk),
        .rst      (rst),
        .run      (shifting),
        .phase_hi (state_q == ST_SHIFT_HI),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    // Mode constants pick which SCLK edge samples miso and which launches mosi.
    assign capture_stb = CPHA ? fall_stb : rise_stb;
    assign launch_stb  = CPHA ? rise_stb : fall_stb;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:               if (accept)   state_d = ST_SETUP;
            ST_SETUP, ST_SHIFT_LO: if (rise_stb) state_d = ST_SHIFT_HI;
            ST_SHIFT_HI:
                if (fall_stb) state_d = (bit_cnt_q == len_q) ? ST_HOLD : ST_SHIFT_LO;
            ST_HOLD:               if (hold_end) state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.cs_n = '1;
        bus.sclk = CPOL;
        bus.mosi = 1'b0;
        if (state_q != ST_IDLE)      bus.cs_n[cs_q] = 1'b0;
        if (state_q == ST_SHIFT_HI)  bus.sclk = ~CPOL;
        if (shifting)                bus.mosi = tx_sr[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            bit_cnt_q  <= '0;
            cs_q       <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            rx_q       <= '0;
            hold_cnt_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= hold_end;
            err_q      <= (state_q == ST_IDLE) && bus.start && !req_ok;
            hold_cnt_q <= ((state_q == ST_HOLD) && !hold_end) ? hold_cnt_q + DIV_W'(1) : '0;
            if (accept) begin
                len_q     <= bus.len;
                cs_q      <= bus.cs_sel;
                tx_sr     <= bus.tx;
                rx_sr     <= '0;
                bit_cnt_q <= '0;
            end
            if (capture_stb) rx_sr[wr_idx] <= bus.miso;
            if (rise_stb)    bit_cnt_q <= bit_cnt_q + LEN_W'(1);
            if (launch_stb)  tx_sr <= {tx_sr[1:MAX_BITS-1], 1'b0};
            if (hold_end)    rx_q <= rx_sr;
        end
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.rx   = rx_q;

    a_done_err_excl: assert property (@(posedge clk) disable iff (rst)
        !(bus.done && bus.err));
    a_cs_onehot: assert property (@(posedge clk) disable iff (rst)
        bus.busy |-> $onehot(~bus.cs_n));
endmodule

// File: doc/spi_main_param.md
# spi_main_param

Parametrised successor to the fixed-frame SPI master that drives the AES encrypt/decrypt slaves. It runs a full-duplex SPI mode-0 master with a runtime transfer length of up to MAX_BITS bits and a compile-time SCLK divider. It drives NUM_CS chip selects, adds an explicit busy/done/err handshake, and has a synchronous reset. It sits between the host-side test logic and one or more SPI slaves (AES key/message/result frames of 130 or 258 bits).

## Interface
- MAX_BITS, 258: longest frame in bits; sizes tx/rx.
- LEN_W, $clog2(MAX_BITS+1): width of len.
- CLK_DIV, 2: clk cycles per SCLK half-period (H); must be ≥1.
- NUM_CS, 2: number of slave chip selects.
- CS_W, max(1,$clog2(NUM_CS)): width of cs_sel.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse, sampled only in IDLE.
- len  in  LEN_W  bits to transfer, legal 1..MAX_BITS.
- cs_sel  in  CS_W  slave index, legal 0..NUM_CS-1.
- tx  in  [0:MAX_BITS-1]  transmit frame; tx[0] is sent first.
- rx  out  [0:MAX_BITS-1]  receive frame; rx[i] is the i-th bit received.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle pulse at the end of a transfer.
- err  out  1  one-cycle pulse when start is rejected.
- sclk  out  1  SPI clock; idles low.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.
- cs_n  out  NUM_CS  active-low chip selects; one-hot-low while busy.

## Operation
- States: IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD.
- IDLE, start=1, legal len and cs_sel: latch tx, len and cs_sel into shadow registers; go to SETUP.
- IDLE, start=1, len=0, len>MAX_BITS or cs_sel≥NUM_CS: err pulses the next cycle; stay in IDLE; no pin activity; rx is unchanged.
- SETUP: cs_n[cs_sel]=0; mosi = latched tx[0]. After H cycles go to SHIFT_HI.
- SHIFT_HI: sclk=1 for H cycles. miso is captured on the clk edge that drives sclk 0→1.
- SHIFT_LO: sclk=0 for H cycles; mosi advances to the next bit on the edge that drives sclk 1→0.
- Bit counter counts rising edges. After the falling edge that follows rising edge len-1, go to HOLD.
- HOLD: cs_n stays low and mosi=0 for H cycles. Then cs_n goes all-ones, done=1 for one cycle, busy=0, back to IDLE.
- rx updates only on the done cycle: rx[0:len-1] = received bits, remaining bits = 0. The internal shift register is never exposed mid-transfer.
- start while busy is ignored. No err, and the in-flight transfer is unaffected (shadow registers only).
- rst at any time, including mid-transfer, takes effect on the next clk edge: state IDLE, no done, partial data discarded.

## Timing
- Reset values: cs_n = all ones, sclk=0, mosi=0, rx=0, busy=0, done=0, err=0.
- start sampled at cycle 0 → busy=1 and cs_n low from cycle 1.
- Rising edge k (k=0..len-1) at cycle 1+H+2kH.
- Falling edge k at cycle 1+2H+2kH.
- done, cs_n release and busy low all at cycle 1+(2·len+1)·H.
- A new start is accepted on the done cycle; it is sampled in IDLE on the following edge.
- Minimum cs_n high gap between back-to-back frames is 1 cycle.
- done and err are never high together.

## Structure
- Shared package/header spi_pkg holds:
  - state encoding (5 states);
  - mode constants (CPOL=0, CPHA=0);
  - width helper for LEN_W/CS_W.
- One sub-module, spi_sclk_gen: a half-period counter that emits rise_stb/fall_stb and is held cleared outside SETUP/SHIFT.
- Top level holds the FSM, bit counter, tx/rx shift registers and the cs_n decoder.

## Test plan
- Reset: hold rst 3 cycles mid-idle → cs_n=2'b11, sclk=0, mosi=0, busy=0, rx=0.
- Loopback (miso=mosi), CLK_DIV=2, len=8, tx[0:7]=8'hA5, cs_sel=1:
  - cs_n=2'b01 over cycles 1..34;
  - exactly 8 sclk rises;
  - done at cycle 35;
  - rx[0:7]=8'hA5, rest 0.
- Full frame: miso tied 1, len=258 → done at cycle 1035, rx all ones. Then len=130 with miso=0 → rx all zeros.
- Start while busy: assert start with a different tx at cycle 10 of a len=8 transfer → single done at cycle 35, rx reflects the first tx only, err stays 0.
- Illegal requests: len=0, then len=259, then cs_sel=2 (NUM_CS=2) → err pulse the cycle after each, cs_n stays 2'b11, rx unchanged.
- Reset mid-transfer: rst at cycle 12 of a len=8 transfer → next cycle cs_n=2'b11, sclk=0, busy=0, no done. A following legal start completes normally.
